// File: rtl/bus_resp_ctrl.sv
// bus_resp_ctrl -- return-path controller for CPU data accesses.
//
// It samples the decoder's active-low chip selects when the CPU raises req.
// The access is then timed by one of two mechanisms:
//   - for fixed-latency targets, a per-peripheral wait-state count;
//   - for the UART, its acknowledge strobe, bounded by a timeout.
// The block returns registered read data together with a one-cycle ready
// pulse. Unmapped, multiply-selected and timed-out accesses pulse bus_err
// alongside ready, zero rdata, and bump a saturating error counter.
//
// Parameters:
//   MEM_WS, TC_WS, GPIO_WS, PWM_WS : wait states per target (0..15)
//   TIMEOUT                        : max UART WAIT cycles (1..255)
// Ports:
//   clk, reset        : clock, asynchronous active-high reset
//   req, we           : CPU request (held until ready), write flag
//   CS_*_N            : active-low decoder selects (MEM, TC, UART, GPIO, PWM)
//   rdata_*           : peripheral read-data buses
//   uart_ack          : UART access-complete strobe
//   rdata             : registered read data to the CPU
//   ready, bus_err    : one-cycle completion / error pulses
//   stall             : req & ~ready, combinational pipeline hold
//   err_cnt           : saturating error count
module bus_resp_ctrl #(
  parameter int unsigned MEM_WS  = 0,
  parameter int unsigned TC_WS   = 1,
  parameter int unsigned GPIO_WS = 1,
  parameter int unsigned PWM_WS  = 1,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic        CS_MEM_N,
  input  logic        CS_TC_N,
  input  logic        CS_UART_N,
  input  logic        CS_GPIO_N,
  input  logic        CS_PWM_N,
  input  logic [31:0] rdata_mem,
  input  logic [31:0] rdata_tc,
  input  logic [31:0] rdata_uart,
  input  logic [31:0] rdata_gpio,
  input  logic [31:0] rdata_pwm,
  input  logic        uart_ack,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        bus_err,
  output logic        stall,
  output logic [7:0]  err_cnt
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP, ERR} state_t;

  state_t      state, state_nxt;
  logic [4:0]  sel_in, sel_q;   // bit 0 MEM, 1 TC, 2 UART, 3 GPIO, 4 PWM
  logic        we_q;
  logic        sel_ok;
  logic [3:0]  ws_cnt, ws_load;
  logic [7:0]  to_cnt;
  logic        to_hit;
  logic [31:0] rdata_mux;

  assign sel_in = ~{CS_PWM_N, CS_GPIO_N, CS_UART_N, CS_TC_N, CS_MEM_N};
  // Valid only when exactly one select is active.
  assign sel_ok = (sel_in != '0) && ((sel_in & (sel_in - 5'd1)) == '0);
  assign to_hit = (to_cnt == 8'(TIMEOUT - 1));

  always_comb begin
    ws_load = '0;
    if (sel_in[0]) ws_load = 4'(MEM_WS);
    if (sel_in[1]) ws_load = 4'(TC_WS);
    if (sel_in[3]) ws_load = 4'(GPIO_WS);
    if (sel_in[4]) ws_load = 4'(PWM_WS);
  end

  // sel_q is one-hot whenever this is consumed, so an AND-OR mux suffices.
  always_comb begin
    rdata_mux = '0;
    rdata_mux = rdata_mux | ({32{sel_q[0]}} & rdata_mem);
    rdata_mux = rdata_mux | ({32{sel_q[1]}} & rdata_tc);
    rdata_mux = rdata_mux | ({32{sel_q[2]}} & rdata_uart);
    rdata_mux = rdata_mux | ({32{sel_q[3]}} & rdata_gpio);
    rdata_mux = rdata_mux | ({32{sel_q[4]}} & rdata_pwm);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (req) state_nxt = sel_ok ? WAIT : ERR;
      end
      WAIT: begin
        if (sel_q[2]) begin
          // Ack is checked first so it wins over a coincident timeout.
          if (uart_ack)    state_nxt = RESP;
          else if (to_hit) state_nxt = ERR;
        end else if (ws_cnt == '0) begin
          state_nxt = RESP;
        end
      end
      RESP:    state_nxt = IDLE;
      ERR:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sel_q   <= '0;
      we_q    <= 1'b0;
      ws_cnt  <= '0;
      to_cnt  <= '0;
      rdata   <= '0;
      err_cnt <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req) begin
            sel_q  <= sel_in;
            we_q   <= we;
            ws_cnt <= ws_load;
            to_cnt <= '0;
          end
        end
        WAIT: begin
          if (sel_q[2]) begin
            if (uart_ack) begin
              if (!we_q) rdata <= rdata_uart;
            end else begin
              to_cnt <= to_cnt + 8'd1;
            end
          end else if (ws_cnt == '0) begin
            if (!we_q) rdata <= rdata_mux;
          end else begin
            ws_cnt <= ws_cnt - 4'd1;
          end
        end
        ERR: begin
          rdata <= '0;
          if (err_cnt != '1) err_cnt <= err_cnt + 8'd1;
        end
        default: ;
      endcase
    end
  end

  assign ready   = (state == RESP) || (state == ERR);
  assign bus_err = (state == ERR);
  assign stall   = req & ~ready;

endmodule

// File: doc/bus_resp_ctrl.md
# bus_resp_ctrl

Bus response controller for the MIPS SoC: the return-path counterpart to the address decoder. It samples the active-low chip selects the decoder produces for each CPU access, times the access with per-peripheral wait states or the UART acknowledge, and returns registered read data with a one-cycle `ready` pulse. Unmapped, multiply-selected and timed-out accesses are flagged on `bus_err`. The block sits between the CPU data port, which stalls until `ready`, and the peripheral read-data buses.

## Interface
- `MEM_WS`, 0: wait states for memory, 4-bit, 0..15
- `TC_WS`, 1: wait states for the timer/counter, 4-bit
- `GPIO_WS`, 1: wait states for GPIO, 4-bit
- `PWM_WS`, 1: wait states for PWM, 4-bit
- `TIMEOUT`, 16: maximum WAIT cycles for the UART acknowledge, 8-bit, 1..255
- `clk` in 1: system clock; all state updates on the rising edge
- `reset` in 1: asynchronous, active-high
- `req` in 1: CPU access request, held with the address until `ready`
- `we` in 1: 1 = write, 0 = read
- `CS_MEM_N`, `CS_TC_N`, `CS_UART_N`, `CS_GPIO_N`, `CS_PWM_N` in 1 each: active-low selects from the decoder
- `rdata_mem`, `rdata_tc`, `rdata_uart`, `rdata_gpio`, `rdata_pwm` in 32 each: peripheral read data
- `uart_ack` in 1: UART access-complete strobe
- `rdata` out 32: registered read data returned to the CPU
- `ready` out 1: one-cycle access-complete pulse
- `bus_err` out 1: one-cycle error pulse, always coincident with `ready`
- `stall` out 1: `req & ~ready`, combinational; the CPU pipeline hold
- `err_cnt` out 8: count of errors, saturating at 255

## Operation
- FSM states: IDLE, WAIT, RESP, ERR.
- **IDLE**
  - `req`=1 captures `sel` = the inverted chip selects (5-bit one-hot) and `we`.
  - If `sel` is zero or has more than one bit set, go to ERR.
  - Otherwise load `ws_cnt` with the target's WS parameter, clear `to_cnt`, and go to WAIT.
- **WAIT, non-UART target**
  - `ws_cnt`==0: on a read, capture the selected `rdata_*` into `rdata`; go to RESP.
  - Otherwise decrement `ws_cnt`.
- **WAIT, UART target**
  - `uart_ack`=1: on a read, capture `rdata_uart`; go to RESP.
  - Otherwise increment `to_cnt`; when `to_cnt` reaches `TIMEOUT-1` without an ack, go to ERR.
  - If `uart_ack` and the timeout arrive in the same cycle, the ack wins.
- **RESP**: `ready`=1 for this cycle; go to IDLE.
- **ERR**: `ready`=1, `bus_err`=1, `rdata` loaded with 32'h0 (reads and writes); `err_cnt` increments unless already 255; go to IDLE.
- Writes never alter `rdata` except in ERR.
- `req` and chip-select changes after capture are ignored until the access completes; the access always finishes.
- `req` seen in RESP or ERR is not a new access. The CPU advances on `ready`, so the next access is sampled in IDLE.

## Timing
- **Reset values**: state IDLE, `rdata`=0, `ready`=0, `bus_err`=0, `err_cnt`=0, `sel`=0, `ws_cnt`=0, `to_cnt`=0. `stall` follows `req`.
- **Reset mid-access**: the access is abandoned, with no `ready` pulse.
- **Fixed-latency targets**: `req` sampled in IDLE at edge n gives `ready` high in cycle n+2+WS. For MEM_WS=0, `ready` is high in the second cycle after the IDLE sample.
- **UART**: `uart_ack` high in WAIT cycle k gives `ready` in cycle k+1.
- **UART timeout**: ERR is entered after `TIMEOUT` WAIT cycles, so `ready`/`bus_err` are high in cycle n+2+TIMEOUT.
- **Decode error**: ERR is entered directly from IDLE, so `ready`/`bus_err` are high in cycle n+1.
- **Throughput**: minimum 3 cycles per access (IDLE, WAIT, RESP). Back-to-back requests are sampled in the IDLE cycle following RESP/ERR.
- `rdata` is valid in the `ready` cycle and holds until the next read capture or ERR.

## Test plan
- **Memory read**: `CS_MEM_N`=0, `rdata_mem`=32'h1234_5678, `req`=1, MEM_WS=0 -> `ready` 2 cycles after the IDLE sample, `rdata`=32'h1234_5678, `bus_err`=0.
- **GPIO read with wait state**: GPIO_WS=1, `rdata_gpio`=32'hA5 -> `ready` 3 cycles after the IDLE sample. `rdata_gpio` changed to 32'hFF after the capture edge does not alter `rdata`.
- **UART acknowledge**: UART read with `uart_ack` pulsed in the 5th WAIT cycle -> `ready` in the next cycle with `rdata`=`rdata_uart`. Repeat with no ack and TIMEOUT=16 -> `ready`=`bus_err`=1 after 16 WAIT cycles, `rdata`=0, `err_cnt`=1.
- **Decode errors and saturation**: all selects high, then two selects low -> each gives `ready`=`bus_err`=1 one cycle after the IDLE sample. 300 consecutive errors -> `err_cnt`=255.
- **Write then read**: write to PWM, then a read from TC with `rdata_tc`=32'h7 -> the write's `ready` leaves `rdata` unchanged; the read returns 32'h7. The second access is sampled in the IDLE cycle after RESP, with no lost or duplicated `ready`.
- **Reset mid-access**: `reset` asserted during a UART WAIT -> all outputs go to their reset values immediately, with no `ready`. After release, a new memory read completes normally.
